// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths and types for the KGP-RISC ALU adder
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int CLA_GROUP = 4;

    typedef logic [ALU_WIDTH-1:0] word_t;

endpackage

// File: rtl/cla_4bit.sv
// rtl/cla_4bit.sv - 4-bit carry-lookahead group with group generate/propagate
module cla_4bit
    import alu_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a,
    input  logic [CLA_GROUP-1:0] b,
    input  logic                 cin,
    output logic [CLA_GROUP-1:0] sum,
    output logic                 cout,
    output logic                 grp_g,
    output logic                 grp_p
);

    logic [CLA_GROUP-1:0] g;
    logic [CLA_GROUP-1:0] p;
    logic [CLA_GROUP-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every internal carry is expanded directly from cin, with no ripple inside the group
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign grp_p = &p;

    assign cout = grp_g | (grp_p & cin);
    assign sum  = p ^ c;

endmodule

// File: rtl/alu_adder.sv
// rtl/alu_adder.sv - 32-bit CLA adder with registered sum and carry-out
module alu_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH  // must be a multiple of CLA_GROUP
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             C
);

    localparam int NGRP = WIDTH / CLA_GROUP;

    logic [NGRP:0]      carry;
    logic [WIDTH-1:0]   sum_next;
    logic [NGRP-1:0]    grp_g;
    logic [NGRP-1:0]    grp_p;
    logic               unused_grp;

    assign carry[0] = 1'b0;

    // Group carries ripple from one CLA group to the next
    for (genvar i = 0; i < NGRP; i++) begin : g_grp
        cla_4bit u_cla (
            .a     (A[i*CLA_GROUP +: CLA_GROUP]),
            .b     (B[i*CLA_GROUP +: CLA_GROUP]),
            .cin   (carry[i]),
            .sum   (sum_next[i*CLA_GROUP +: CLA_GROUP]),
            .cout  (carry[i+1]),
            .grp_g (grp_g[i]),
            .grp_p (grp_p[i])
        );
    end

    // Group generate/propagate are exported for a future second-level lookahead
    assign unused_grp = ^{grp_g, grp_p};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            S <= '0;
            C <= 1'b0;
        end else begin
            S <= sum_next;
            C <= carry[NGRP];
        end
    end

endmodule

// File: tb/tb_alu_adder.sv
// tb/tb_alu_adder.sv - scoreboard bench for the registered CLA adder
module tb_alu_adder;

    logic        CLK;
    logic        RST_N;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] S;
    logic        C;

    logic [32:0] sb[$];
    logic [32:0] last_exp;
    int          errors;
    int          checks;

    alu_adder #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .A     (A),
        .B     (B),
        .S     (S),
        .C     (C)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive operands on the falling edge, queue the reference, compare after the next rising edge
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] exp;
        @(negedge CLK);
        A = a;
        B = b;
        sb.push_back({1'b0, a} + {1'b0, b});
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_empty"}, {C, S}, 33'h1_ffff_ffff);
        end else begin
            exp = sb.pop_front();
            last_exp = exp;
            chk(tag, {C, S}, exp);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        last_exp = '0;
        RST_N    = 1'b0;
        A        = 32'h1234_5678;
        B        = 32'h0000_0001;

        #1;
        chk("reset_initial", {C, S}, 33'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            chk("reset_hold", {C, S}, 33'h0);
        end

        @(negedge CLK);
        RST_N = 1'b1;
        sb.push_back({1'b0, A} + {1'b0, B});
        @(posedge CLK);
        #1;
        chk("reset_release", {C, S}, sb.pop_front());
        chk("reset_release_const", {C, S}, 33'h0_1234_5679);

        step("zero_zero", 32'h0, 32'h0);
        chk("zero_zero_const", {C, S}, 33'h0);
        step("wrap_2pow32", 32'h2, 32'hffff_fffe);
        chk("wrap_2pow32_const", {C, S}, 33'h1_0000_0000);
        step("sum_56_44", 32'd56, 32'd44);
        chk("sum_56_44_const", {C, S}, 33'd100);
        step("sum_99_4", 32'd99, 32'd4);
        chk("sum_99_4_const", {C, S}, 33'd103);
        step("all_ones_plus_1", 32'hffff_ffff, 32'h1);
        chk("all_ones_plus_1_const", {C, S}, 33'h1_0000_0000);
        step("max_plus_max", 32'hffff_ffff, 32'hffff_ffff);
        chk("max_plus_max_const", {C, S}, 33'h1_ffff_fffe);
        step("group_cross", 32'h0000_000f, 32'h1);
        chk("group_cross_const", {C, S}, 33'h0_0000_0010);
        step("mid_chain", 32'h00ff_ff00, 32'h0000_0100);

        for (int i = 0; i < 1000; i++) begin
            step("random_stream", $urandom, $urandom);
        end

        // Operand change with no clock edge must not reach the outputs
        step("latency_base", 32'h0000_1000, 32'h0000_0234);
        A = 32'h7000_0000;
        #2;
        chk("latency_hold", {C, S}, last_exp);
        sb.push_back({1'b0, A} + {1'b0, B});
        @(posedge CLK);
        #1;
        chk("latency_update", {C, S}, sb.pop_front());

        step("pre_async", 32'h0000_0005, 32'h0000_0007);
        @(negedge CLK);
        A = 32'h8000_0000;
        B = 32'h8000_0000;
        #1;
        RST_N = 1'b0;
        #1;
        chk("async_reset_drop", {C, S}, 33'h0);
        @(posedge CLK);
        #1;
        chk("async_reset_hold", {C, S}, 33'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        sb.push_back({1'b0, A} + {1'b0, B});
        @(posedge CLK);
        #1;
        chk("async_release", {C, S}, sb.pop_front());
        chk("async_release_const", {C, S}, 33'h1_0000_0000);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_adder.md
Name: alu_adder

Overview:
- 32-bit unsigned binary adder for the KGP-RISC ALU datapath; produces sum S and carry-out C of operands A and B.
- Carry-lookahead core; the sum and carry are registered on the clock with one-cycle latency.
- The ALU result mux consumes S; flag/branch logic consumes C.

Parameters:
- WIDTH, 32, operand and sum width; must be a multiple of 4 (CLA group size).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- S  output  WIDTH  registered sum, A+B modulo 2^WIDTH.
- C  output  1  registered carry-out of bit WIDTH-1.

Behaviour:
- Clocking and reset:
  - One clock, CLK. Reset is asynchronous and active-low on RST_N.
  - While RST_N=0: S=0 and C=0 immediately, without waiting for a clock edge.
  - On RST_N deassertion, the first rising edge of CLK captures the current A+B.
- Arithmetic:
  - The combinational result is {C_next, S_next} = A + B, computed at WIDTH+1 bits.
  - No carry-in.
  - Unsigned semantics. C is the unsigned overflow indicator; no signed overflow flag.
- Latency and throughput:
  - Exactly 1 cycle: operands stable before rising edge n produce S/C valid after edge n.
  - New operands are accepted every cycle; no handshake, no stall.
  - S and C are never combinationally dependent on A/B.
- Carry structure:
  - 4-bit CLA groups, each producing generate/propagate signals and a group carry.
  - Group carries are chained (rippled) group to group; carry into group 0 is 0.
- Boundary conditions:
  - A+B = 2^WIDTH (e.g. 2 + 0xFFFFFFFE): S=0, C=1.
  - Max+max: S = 0xFFFFFFFE, C=1.
  - 0+0: S=0, C=0.
  - Reset asserted mid-stream: outputs go to 0 asynchronously; the pending result is discarded.
  - X/Z on inputs are not handled specially.
- No internal state beyond the WIDTH+1 output register.

Decomposition:
- Shared package alu_pkg:
  - localparam ALU_WIDTH = 32.
  - localparam CLA_GROUP = 4.
  - typedef word_t = logic [ALU_WIDTH-1:0].
- One sub-module, cla_4bit: inputs a[3:0], b[3:0], cin; outputs sum[3:0], cout, grp_g, grp_p.
- alu_adder instantiates WIDTH/4 copies of cla_4bit via a generate loop, then registers the result.

Test Plan:
- Reset: hold RST_N=0 with A=0x12345678, B=1 and toggle CLK -> S=0, C=0 throughout; then release RST_N -> the first edge gives S=0x12345679, C=0.
- Directed sums, one per cycle, each checked one cycle later:
  - A=0, B=0 -> S=0, C=0.
  - A=2, B=0xFFFFFFFE -> S=0, C=1.
  - A=56, B=44 -> S=100, C=0.
  - A=99, B=4 -> S=103, C=0.
- Carry chain across all groups: A=0xFFFFFFFF, B=1 -> S=0, C=1; A=0xFFFFFFFF, B=0xFFFFFFFF -> S=0xFFFFFFFE, C=1; A=0x0000000F, B=1 -> S=0x10, C=0 (crosses a group boundary).
- Back-to-back throughput: change operands every cycle over a stream of 1000 random pairs -> each S/C equals the 33-bit reference sum of the operands from the previous cycle; no bubbles.
- Async reset mid-operation: drive A=0x80000000, B=0x80000000, then assert RST_N=0 between clock edges -> S and C drop to 0 before the next edge; after release, the next edge gives S=0, C=1.
- Latency check: change A between edges without a clock edge -> S and C remain unchanged until the next rising edge.
